// File: rtl/vmem_lane_seq.sv
// Vector memory sequencer: serialises up to NUM_LANES strided elements onto the
// single data-memory port, yielding the port to the protocol controller on demand.
module vmem_lane_seq #(
    parameter int NUM_LANES  = 4,
    parameter int ADDR_BITS  = 12,
    parameter int DATA_WIDTH = 32,
    parameter int VL_BITS    = $clog2(NUM_LANES + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_is_store,
    input  logic [ADDR_BITS-1:0]            req_base,
    input  logic [ADDR_BITS-1:0]            req_stride,
    input  logic [VL_BITS-1:0]              req_vl,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] store_data,
    output logic [NUM_LANES*DATA_WIDTH-1:0] load_data,
    output logic                            done,
    output logic                            busy,
    input  logic                            con_req,
    input  logic [ADDR_BITS-1:0]            con_addr,
    input  logic [3:0]                      con_we,
    input  logic [DATA_WIDTH-1:0]           con_wdata,
    output logic                            con_gnt,
    output logic [DATA_WIDTH-1:0]           con_rdata,
    output logic                            mem_en,
    output logic [ADDR_BITS-1:0]            mem_addr,
    output logic [3:0]                      mem_we,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);
    // state | meaning
    // IDLE  | waiting for a vector request; port free for the controller
    // ISSUE | one element per cycle unless the controller holds the port
    // DRAIN | load only: waiting for the last read word to be captured
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [VL_BITS-1:0] LANES_VL = VL_BITS'(NUM_LANES);

    state_t                state;
    logic                  is_store;
    logic [ADDR_BITS-1:0]  stride;
    logic [ADDR_BITS-1:0]  cur_addr;
    logic [VL_BITS-1:0]    vl_eff;
    logic [VL_BITS-1:0]    idx;
    logic [VL_BITS-1:0]    cap_tag;
    logic                  cap_valid;
    logic                  issue_fire;
    logic [VL_BITS-1:0]    req_vl_eff;
    logic [DATA_WIDTH-1:0] lane_wdata;

    assign req_ready  = (state == IDLE);
    assign con_gnt    = con_req;
    assign con_rdata  = mem_rdata;
    assign issue_fire = (state == ISSUE) && !con_req;
    assign req_vl_eff = (req_vl > LANES_VL) ? LANES_VL : req_vl;

    always_comb begin
        lane_wdata = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (idx == VL_BITS'(i)) lane_wdata = store_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Controller always wins the port; the vector side only drives it in ISSUE.
    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_we    = 4'h0;
        mem_wdata = '0;
        if (con_req) begin
            mem_en    = 1'b1;
            mem_addr  = con_addr;
            mem_we    = con_we;
            mem_wdata = con_wdata;
        end else if (state == ISSUE) begin
            mem_en   = 1'b1;
            mem_addr = cur_addr;
            if (is_store) begin
                mem_we    = 4'hF;
                mem_wdata = lane_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_store  <= 1'b0;
            stride    <= '0;
            cur_addr  <= '0;
            vl_eff    <= '0;
            idx       <= '0;
            cap_tag   <= '0;
            cap_valid <= 1'b0;
            load_data <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done      <= 1'b0;
            cap_valid <= issue_fire && !is_store;
            cap_tag   <= idx;
            // Capture lands one cycle after its issue, whoever owns the port now.
            if (cap_valid) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (cap_tag == VL_BITS'(i)) load_data[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                end
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_store  <= req_is_store;
                        stride    <= req_stride;
                        cur_addr  <= req_base;
                        vl_eff    <= req_vl_eff;
                        idx       <= '0;
                        load_data <= '0;
                        if (req_vl_eff == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!con_req) begin
                        idx      <= idx + VL_BITS'(1);
                        cur_addr <= cur_addr + stride;
                        if (idx == vl_eff - VL_BITS'(1)) begin
                            if (is_store) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (cap_valid) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vmem_lane_seq.sv
// Scoreboard bench for vmem_lane_seq: stimulus pushes expected port accesses and
// completions computed from address arithmetic; a negedge monitor pops and compares.
module tb_vmem_lane_seq;
    localparam int NL  = 4;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int VLB = $clog2(NL + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_is_store = 1'b0;
    logic [AW-1:0]     req_base = '0;
    logic [AW-1:0]     req_stride = '0;
    logic [VLB-1:0]    req_vl = '0;
    logic [NL*DW-1:0]  store_data = '0;
    logic [NL*DW-1:0]  load_data;
    logic              done;
    logic              busy;
    logic              con_req = 1'b0;
    logic [AW-1:0]     con_addr = '0;
    logic [3:0]        con_we = 4'h0;
    logic [DW-1:0]     con_wdata = '0;
    logic              con_gnt;
    logic [DW-1:0]     con_rdata;
    logic              mem_en;
    logic [AW-1:0]     mem_addr;
    logic [3:0]        mem_we;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;

    vmem_lane_seq #(.NUM_LANES(NL), .ADDR_BITS(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_base(req_base), .req_stride(req_stride),
        .req_vl(req_vl), .store_data(store_data), .load_data(load_data), .done(done),
        .busy(busy), .con_req(con_req), .con_addr(con_addr), .con_we(con_we),
        .con_wdata(con_wdata), .con_gnt(con_gnt), .con_rdata(con_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {a, 4'h5, ~a, 4'hA};
    endfunction

    // Memory environment: unwritten words read back as init_word(addr).
    logic [DW-1:0] mem [1<<AW];
    bit            mem_wr [1<<AW];
    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (mem_en) begin
            w = mem_wr[mem_addr] ? mem[mem_addr] : init_word(mem_addr);
            if (mem_we == 4'h0) begin
                mem_rdata <= w;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
                mem[mem_addr]    <= w;
                mem_wr[mem_addr] <= 1'b1;
            end
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    we;
        logic [DW-1:0] wdata;
        int            cyc;
        bit            last;
        bit            is_load;
    } acc_t;
    typedef struct {
        logic [NL*DW-1:0] ld;
        int               cyc;
        int               acc;
        int               vle;
        bit               is_load;
    } done_t;

    acc_t          exp_acc[$];
    done_t         exp_done[$];
    logic [DW-1:0] ref_mem [1<<AW];
    int            errors = 0;
    int            checks = 0;
    bit            sb_on = 1'b1;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    acc_t          m_a;
    done_t         m_d;
    int            last_issue = 0;
    bit            con_rd_pend = 1'b0;
    logic [AW-1:0] con_rd_addr = '0;
    always @(negedge clk) begin
        if (!rst && sb_on) begin
            if (con_rd_pend) chk("con_rdata", 128'(con_rdata), 128'(ref_mem[con_rd_addr]));
            con_rd_pend = 1'b0;
            chk("con_gnt", 128'(con_gnt), 128'(con_req));
            if (con_req) begin
                chk("con_passthrough", 128'({mem_en, mem_addr, mem_we, mem_wdata}),
                    128'({1'b1, con_addr, con_we, con_wdata}));
                if (con_we == 4'h0) begin
                    con_rd_pend = 1'b1;
                    con_rd_addr = con_addr;
                end
            end else if (mem_en) begin
                if (exp_acc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access: addr=%0h we=%0h, no access required", mem_addr, mem_we);
                end else begin
                    m_a = exp_acc.pop_front();
                    chk("vec_addr", 128'(mem_addr), 128'(m_a.addr));
                    chk("vec_we", 128'(mem_we), 128'(m_a.we));
                    if (!m_a.is_load) chk("vec_wdata", 128'(mem_wdata), 128'(m_a.wdata));
                    if (m_a.cyc >= 0) chk("vec_cycle", 128'(cyc), 128'(m_a.cyc));
                    if (m_a.last) last_issue = cyc;
                end
            end else begin
                chk("idle_bus", 128'({mem_addr, mem_we, mem_wdata}), 128'(0));
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 required 0");
                end else begin
                    m_d = exp_done.pop_front();
                    chk("load_data", load_data, m_d.ld);
                    chk("busy_at_done", 128'(busy), 128'(0));
                    chk("accesses_left", 128'(exp_acc.size()), 128'(0));
                    if (m_d.vle == 0) chk("done_cycle", 128'(cyc), 128'(m_d.acc + 1));
                    else chk("done_cycle", 128'(cyc), 128'(last_issue + 1 + int'(m_d.is_load)));
                    if (m_d.cyc >= 0) chk("done_abs_cycle", 128'(cyc), 128'(m_d.cyc));
                end
            end
        end
    end

    task automatic start_req(input bit st, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                             input logic [VLB-1:0] vl, input logic [NL*DW-1:0] sd,
                             input bit exact, output int acc);
        int            vle;
        int            t;
        acc_t          a;
        done_t         d;
        logic [AW-1:0] ad;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req_ready=0 required 1");
        end
        vle = (int'(vl) > NL) ? NL : int'(vl);
        acc = cyc;
        d.ld      = '0;
        d.is_load = !st;
        d.vle     = vle;
        d.acc     = acc;
        d.cyc     = exact ? ((vle == 0) ? acc + 1 : acc + vle + 1 + (st ? 0 : 1)) : -1;
        for (int i = 0; i < vle; i++) begin
            ad        = AW'(int'(base) + i * int'(stride));
            a.addr    = ad;
            a.we      = st ? 4'hF : 4'h0;
            a.wdata   = st ? sd[i*DW +: DW] : '0;
            a.cyc     = exact ? acc + 1 + i : -1;
            a.last    = (i == vle - 1);
            a.is_load = !st;
            if (st) ref_mem[ad] = sd[i*DW +: DW];
            else d.ld[i*DW +: DW] = ref_mem[ad];
            exp_acc.push_back(a);
        end
        exp_done.push_back(d);
        req_valid    = 1'b1;
        req_is_store = st;
        req_base     = base;
        req_stride   = stride;
        req_vl       = vl;
        store_data   = sd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int t;
        t = 0;
        while (!done && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done=0 required 1");
        end
        dc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic run_req(input bit st, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input logic [VLB-1:0] vl, input logic [NL*DW-1:0] sd, input bit exact);
        int acc;
        int dc;
        start_req(st, base, stride, vl, sd, exact, acc);
        wait_done(dc);
    endtask

    bit rand_done = 1'b0;

    initial begin
        int               acc;
        int               dc;
        logic [NL*DW-1:0] sd;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(AW'(i));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", 128'(req_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_load_data", load_data, 128'(0));

        sd = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
        run_req(1'b1, 12'h010, 12'd1, 3'd4, sd, 1'b1);
        run_req(1'b0, 12'h100, 12'd3, 3'd4, '0, 1'b1);
        run_req(1'b0, 12'h010, 12'd1, 3'd4, '0, 1'b1);
        run_req(1'b0, 12'h200, 12'd1, 3'd2, '0, 1'b1);
        run_req(1'b0, 12'h300, 12'd2, 3'd7, '0, 1'b1);
        run_req(1'b1, 12'h040, 12'd1, 3'd0, sd, 1'b1);
        run_req(1'b1, 12'h050, 12'd0, 3'd3, sd, 1'b1);

        // Controller steals cycles 2-3 of a 4-element store.
        sd = {$urandom, $urandom, $urandom, $urandom};
        start_req(1'b1, 12'h020, 12'd1, 3'd4, sd, 1'b0, acc);
        @(posedge clk); #1;
        con_req   = 1'b1;
        con_addr  = 12'h500;
        con_we    = 4'hF;
        con_wdata = 32'hC0DE_5A5A;
        ref_mem[12'h500] = 32'hC0DE_5A5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        con_req = 1'b0;
        con_we  = 4'h0;
        wait_done(dc);
        chk("contention_done_cycle", 128'(dc), 128'(acc + 7));
        run_req(1'b0, 12'h500, 12'd1, 3'd1, '0, 1'b1);
        run_req(1'b0, 12'h020, 12'd1, 3'd4, '0, 1'b1);

        sd = {$urandom, $urandom, $urandom, $urandom};
        run_req(1'b1, 12'hFFE, 12'd1, 3'd4, sd, 1'b1);
        run_req(1'b0, 12'hFFE, 12'd1, 3'd4, '0, 1'b1);

        // Reset after two issues of a load abandons it cleanly.
        sb_on = 1'b0;
        start_req(1'b0, 12'h100, 12'd1, 3'd4, '0, 1'b0, acc);
        exp_acc.delete();
        exp_done.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_lane0", 128'(load_data[DW-1:0]), 128'(ref_mem[12'h100]));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", 128'(req_ready), 128'(1));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_done", 128'(done), 128'(0));
        chk("midrst_load_data", load_data, 128'(0));
        chk("midrst_mem_we", 128'({mem_en, mem_we}), 128'(0));
        @(posedge clk); #1;
        chk("midrst_no_done", 128'(done), 128'(0));
        sb_on = 1'b1;
        run_req(1'b0, 12'h104, 12'd2, 3'd4, '0, 1'b1);

        fork
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    if (!rand_done && $urandom_range(0, 3) == 0) begin
                        con_req   = 1'b1;
                        con_we    = 4'h0;
                        con_addr  = AW'(12'hC00 + $urandom_range(0, 1023));
                        con_wdata = $urandom;
                    end else begin
                        con_req = 1'b0;
                    end
                end
                con_req = 1'b0;
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    sd = {$urandom, $urandom, $urandom, $urandom};
                    run_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 12'h7FF)),
                            AW'($urandom_range(0, 63)), VLB'($urandom_range(0, 7)), sd, 1'b0);
                end
                rand_done = 1'b1;
            end
        join
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("final_acc_queue", 128'(exp_acc.size()), 128'(0));
        chk("final_done_queue", 128'(exp_done.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
